iir_biquad_mac: RTL and testbench

Time-multiplexed second-order IIR (biquad) section that consumes the Q16.16 coefficient table of the filter coefficient ROM directly downstream of it. The block sequences the ROM address, multiplies each returned coefficient against the current input sample or stored history, accumulates five products per sample, and emits one saturated output sample. It uses one multiplier per sample period and sits between the ADC sample stream and the trigger/peak-detect logic.

---
 rtl/iir_biquad_mac.sv | 111 +++++++++++
 tb/tb_iir_biquad_mac.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_mac.sv
// rtl/iir_biquad_mac.sv - time-multiplexed biquad IIR section driving a registered coefficient ROM
module iir_biquad_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int FRAC   = 16,
  parameter int ACC_W  = 52
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int R_W    = ACC_W - FRAC;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x_cur, x1, x2, y1, y2;
  logic signed [ACC_W-1:0]  acc;
  logic [2:0]               cnt;

  logic signed [DATA_W-1:0] operand;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [R_W-1:0]    r;
  logic signed [DATA_W-1:0] y_sat;

  // coef_data at step cnt belongs to the address issued one cycle earlier
  always_comb begin
    operand = y2;
    case (cnt)
      3'd1:    operand = x_cur;
      3'd2:    operand = x1;
      3'd3:    operand = x2;
      3'd4:    operand = y1;
      default: operand = y2;
    endcase
  end

  assign prod     = PROD_W'(coef_data) * PROD_W'(operand);
  assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // dropping the low FRAC bits is an arithmetic shift that rounds toward -inf
  assign r        = acc_next[ACC_W-1:FRAC];

  always_comb begin
    y_sat = r[DATA_W-1:0];
    if (!(&r[R_W-1:DATA_W-1]) && (|r[R_W-1:DATA_W-1])) begin
      if (r[R_W-1]) y_sat = {1'b1, {(DATA_W-1){1'b0}}};
      else          y_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_cur     <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      cnt       <= '0;
      coef_addr <= '0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            x_cur     <= x_in;
            acc       <= '0;
            cnt       <= '0;
            coef_addr <= 3'd0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (x_valid) overrun <= 1'b1;
          cnt       <= cnt + 3'd1;
          coef_addr <= (cnt >= 3'd3) ? 3'd4 : cnt + 3'd1;
          if (cnt >= 3'd1 && cnt <= 3'd4) acc <= acc_next;
          if (cnt == 3'd5) begin
            y_out     <= y_sat;
            y_valid   <= 1'b1;
            x2        <= x1;
            x1        <= x_cur;
            y2        <= y1;
            y1        <= y_sat;
            busy      <= 1'b0;
            coef_addr <= 3'd0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_mac.sv
// tb/tb_iir_biquad_mac.sv - bench for iir_biquad_mac with registered coefficient ROM and difference-equation model
module tb_iir_biquad_mac;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] x_in = '0;
  logic               x_valid = 1'b0;
  logic [2:0]         coef_addr;
  logic signed [31:0] coef_data;
  logic signed [15:0] y_out;
  logic               y_valid, busy, overrun;

  logic signed [31:0] coef_tab [0:7];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iir_biquad_mac dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  always @(posedge clk) coef_data <= coef_tab[coef_addr];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // age = edges since the sample was accepted (-1 when idle)
  int  age = -1;
  int  mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  int  m_pend = 0, m_yout = 0;
  bit  m_ovr = 0;
  bit  armed = 0;

  always @(negedge clk) begin
    int     e_addr;
    bit     take;
    longint a, r;
    int     nx;
    if (armed) begin
      e_addr = (age >= 0 && age <= 4) ? age : ((age == 5) ? 4 : 0);
      chk("y_valid", y_valid, age == 6);
      chk("busy", busy, age >= 0 && age <= 5);
      chk("overrun", overrun, m_ovr);
      chk("coef_addr", coef_addr, e_addr);
      chk("y_out", y_out, m_yout);
    end
    if (reset) begin
      age = -1; mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      m_pend = 0; m_yout = 0; m_ovr = 0; armed = 1;
    end else if (armed) begin
      take = x_valid && (age < 0 || age == 6);
      if (x_valid && !take) m_ovr = 1;
      if (take) begin
        nx = int'(x_in);
        a = longint'(coef_tab[0]) * nx + longint'(coef_tab[1]) * mx1 + longint'(coef_tab[2]) * mx2
          + longint'(coef_tab[3]) * my1 + longint'(coef_tab[4]) * my2;
        r = a >>> 16;
        m_pend = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : int'(r));
        mx2 = mx1; mx1 = nx; my2 = my1; my1 = m_pend;
        age = 0;
      end else if (age >= 0 && age < 6) begin
        age++;
        if (age == 6) m_yout = m_pend;
      end else begin
        age = -1;
      end
    end
  end

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3, input int c4);
    @(posedge clk); #1;
    coef_tab[0] = c0; coef_tab[1] = c1; coef_tab[2] = c2; coef_tab[3] = c3; coef_tab[4] = c4;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic send(input int x);
    @(posedge clk); #1; x_in = 16'(x); x_valid = 1'b1;
    @(posedge clk); #1; x_valid = 1'b0;
  endtask

  task automatic wait_y(input string name, input int exp, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!y_valid && lat < 20);
    chk({name, "_seen"}, y_valid, 1);
    chk(name, y_out, exp);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 8; i++) coef_tab[i] = 0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_y_out", y_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    set_coef(32'h10000, 0, 0, 0, 0);
    send(1000);
    wait_y("unity", 1000, lat);
    chk("latency", lat, 7);
    chk("busy_in_yv", busy, 0);
    @(negedge clk);
    chk("yv_one_cycle", y_valid, 0);

    do_reset();
    set_coef(0, 32'h10000, 0, 0, 0);
    send(100); wait_y("delay0", 0, lat);
    send(200); wait_y("delay1", 100, lat);
    send(300); wait_y("delay2", 200, lat);

    do_reset();
    set_coef(32'h10000, 0, 0, 32'h8000, 0);
    send(1000); wait_y("fb0", 1000, lat);
    send(0);    wait_y("fb1", 500, lat);
    send(0);    wait_y("fb2", 250, lat);
    send(0);    wait_y("fb3", 125, lat);
    do_reset();
    set_coef(32'h8000, 0, 0, 0, 0);
    send(-1);   wait_y("floor", -1, lat);

    do_reset();
    set_coef(32'h20000, 0, 0, 0, 0);
    send(20000); wait_y("sat_hi", 32767, lat);
    set_coef(32'h20000, 0, 0, 32'h10000, 0);
    send(0);     wait_y("sat_hist", 32767, lat);
    do_reset();
    set_coef(32'h20000, 0, 0, 0, 0);
    send(-20000); wait_y("sat_lo", -32768, lat);

    do_reset();
    set_coef(32'h10000, 0, 0, 0, 0);
    send(700);
    @(posedge clk); #1; x_in = 16'(5); x_valid = 1'b1;
    @(posedge clk); #1; x_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; x_in = -16'sd300; x_valid = 1'b1;
    @(negedge clk);
    chk("ovr_first_yv", y_valid, 1);
    chk("ovr_first_y", y_out, 700);
    chk("ovr_sticky", overrun, 1);
    @(posedge clk); #1; x_valid = 1'b0;
    wait_y("back_to_back", -300, lat);
    chk("ovr_unchanged", overrun, 1);

    do_reset();
    set_coef(32'h10000, 0, 0, 0, 0);
    send(1234); wait_y("pre_abort", 1234, lat);
    send(4321);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_y_out", y_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);
    set_coef(0, 32'h10000, 0, 0, 0);
    send(500); wait_y("hist_cleared", 0, lat);

    for (int k = 0; k < 400; k++) begin
      if (k % 40 == 0) begin
        repeat (10) @(posedge clk);
        set_coef($urandom_range(0, 32'h30000) - 32'h18000, $urandom_range(0, 32'h30000) - 32'h18000,
                 $urandom_range(0, 32'h30000) - 32'h18000, $urandom_range(0, 32'h20000) - 32'h10000,
                 $urandom_range(0, 32'h10000) - 32'h8000);
        if ($urandom_range(0, 1) == 1) do_reset();
      end
      repeat ($urandom_range(0, 9)) @(posedge clk);
      send(int'($urandom_range(0, 65535)) - 32768);
    end
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
